tracer_frame_buffer: RTL and testbench

TRACER_FRAME_BUFFER -- requirements
Module: tracer_frame_buffer

---
 rtl/tracer_pkg.sv | 13 +
 rtl/tracer_bank_ram.sv | 32 +++
 rtl/tracer_frame_buffer.sv | 110 +++++++++++
 tb/tb_tracer_frame_buffer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tracer_pkg.sv
// Shared defaults and state encoding for the tracer frame buffer.
package tracer_pkg;

    localparam int COL_W_DEF   = 7;
    localparam int ROW_W_DEF   = 6;
    localparam int COLOR_W_DEF = 12;

    typedef enum logic {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } fb_state_e;

endpackage

// File: rtl/tracer_bank_ram.sv
// One frame bank: single write port and a registered read port.
module tracer_bank_ram #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the read register is cleared; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/tracer_frame_buffer.sv
// Double-buffered frame store: tracer fills the back bank in raster order,
// display reads the front bank, banks swap on vsync once a frame is complete.
module tracer_frame_buffer
    import tracer_pkg::*;
#(
    parameter int COL_W   = COL_W_DEF,
    parameter int ROW_W   = ROW_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF
) (
    input  logic               tracer_clk,
    input  logic               rst,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [COL_W-1:0]   pix_col,
    input  logic [ROW_W-1:0]   pix_row,
    input  logic [COLOR_W-1:0] pix_color,
    input  logic [COL_W-1:0]   disp_col,
    input  logic [ROW_W-1:0]   disp_row,
    output logic [COLOR_W-1:0] disp_color,
    input  logic               disp_vsync,
    output logic               bank_sel,
    output logic               frame_done,
    output logic               seq_err
);

    localparam int ADDR_W = COL_W + ROW_W;

    fb_state_e           state;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   exp_addr;
    logic                transfer;
    logic                last_pix;
    logic                rd_sel;
    logic [COLOR_W-1:0]  rd_data0;
    logic [COLOR_W-1:0]  rd_data1;

    assign wr_addr   = {pix_row, pix_col};
    assign rd_addr   = {disp_row, disp_col};
    assign pix_ready = (state == FILL);
    assign transfer  = pix_valid && pix_ready;
    assign last_pix  = &wr_addr;

    // The raster counter is {row,col}, so a plain increment wraps col into row
    // and the last pixel back to (0,0); on a mismatch it resyncs to the input.
    always_ff @(posedge tracer_clk) begin
        if (rst) begin
            state      <= FILL;
            bank_sel   <= 1'b0;
            frame_done <= 1'b0;
            seq_err    <= 1'b0;
            exp_addr   <= '0;
            rd_sel     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            rd_sel     <= bank_sel;
            case (state)
                FILL: begin
                    if (transfer) begin
                        if (wr_addr != exp_addr) begin
                            seq_err <= 1'b1;
                        end
                        exp_addr <= wr_addr + 1'b1;
                        if (last_pix) begin
                            state <= WAIT_SWAP;
                        end
                    end
                end
                WAIT_SWAP: begin
                    if (disp_vsync) begin
                        bank_sel   <= ~bank_sel;
                        frame_done <= 1'b1;
                        state      <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    tracer_bank_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (COLOR_W)
    ) u_bank0 (
        .clk     (tracer_clk),
        .rst     (rst),
        .we      (transfer && bank_sel),
        .wr_addr (wr_addr),
        .wr_data (pix_color),
        .rd_addr (rd_addr),
        .rd_data (rd_data0)
    );

    tracer_bank_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (COLOR_W)
    ) u_bank1 (
        .clk     (tracer_clk),
        .rst     (rst),
        .we      (transfer && !bank_sel),
        .wr_addr (wr_addr),
        .wr_data (pix_color),
        .rd_addr (rd_addr),
        .rd_data (rd_data1)
    );

    // Mux with the bank index registered alongside the read address.
    assign disp_color = rd_sel ? rd_data1 : rd_data0;

endmodule

// File: tb/tb_tracer_frame_buffer.sv
// Self-checking bench for tracer_frame_buffer against a frame-level reference model.
module tb_tracer_frame_buffer;

    localparam int NPIX = 8192;

    logic        tracer_clk = 1'b0;
    logic        rst        = 1'b1;
    logic        pix_valid  = 1'b0;
    logic        pix_ready;
    logic [6:0]  pix_col    = '0;
    logic [5:0]  pix_row    = '0;
    logic [11:0] pix_color  = '0;
    logic [6:0]  disp_col   = '0;
    logic [5:0]  disp_row   = '0;
    logic [11:0] disp_color;
    logic        disp_vsync = 1'b0;
    logic        bank_sel;
    logic        frame_done;
    logic        seq_err;

    int errors = 0;
    int checks = 0;

    // Reference model: two banks of known pixels, front index, frame state.
    int ref_mem   [2][NPIX];
    bit ref_known [2][NPIX];
    int ref_bank;
    bit ref_wait;
    bit ref_seq;
    int ref_exp;
    bit ref_fd;
    int dut_transfers;

    tracer_frame_buffer dut (
        .tracer_clk (tracer_clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_col    (pix_col),
        .pix_row    (pix_row),
        .pix_color  (pix_color),
        .disp_col   (disp_col),
        .disp_row   (disp_row),
        .disp_color (disp_color),
        .disp_vsync (disp_vsync),
        .bank_sel   (bank_sel),
        .frame_done (frame_done),
        .seq_err    (seq_err)
    );

    always #5 tracer_clk = ~tracer_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare registered outputs.
    task automatic applyStimulus(input bit r, input bit v, input int col, input int row,
                                 input int color, input bit vs, input int dcol, input int drow);
        int  idx;
        int  ridx;
        bit  disp_known;
        int  disp_exp;
        rst        = r;
        pix_valid  = v;
        pix_col    = col[6:0];
        pix_row    = row[5:0];
        pix_color  = color[11:0];
        disp_vsync = vs;
        disp_col   = dcol[6:0];
        disp_row   = drow[5:0];
        #1;
        checkOutput("pix_ready", pix_ready, !ref_wait);
        if (v && pix_ready) dut_transfers++;
        ridx       = drow * 128 + dcol;
        disp_known = ref_known[ref_bank][ridx];
        disp_exp   = ref_mem[ref_bank][ridx];
        ref_fd     = 1'b0;
        if (r) begin
            ref_wait   = 1'b0;
            ref_bank   = 0;
            ref_seq    = 1'b0;
            ref_exp    = 0;
            disp_known = 1'b1;
            disp_exp   = 0;
        end else if (!ref_wait) begin
            if (v) begin
                idx = row * 128 + col;
                if (idx != ref_exp) ref_seq = 1'b1;
                ref_mem[1 - ref_bank][idx]   = color & 12'hFFF;
                ref_known[1 - ref_bank][idx] = 1'b1;
                ref_exp = (idx + 1) % NPIX;
                if (idx == NPIX - 1) ref_wait = 1'b1;
            end
        end else if (vs) begin
            ref_bank = 1 - ref_bank;
            ref_wait = 1'b0;
            ref_fd   = 1'b1;
        end
        @(posedge tracer_clk);
        #1;
        checkOutput("bank_sel", bank_sel, ref_bank);
        checkOutput("frame_done", frame_done, ref_fd);
        checkOutput("seq_err", seq_err, ref_seq);
        if (disp_known) checkOutput("disp_color", disp_color, disp_exp);
    endtask

    initial begin
        int guard;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NPIX; i++) ref_known[b][i] = 1'b0;
        ref_bank = 0;
        ref_wait = 1'b0;
        ref_seq  = 1'b0;
        ref_exp  = 0;
        ref_fd   = 1'b0;
        dut_transfers = 0;

        @(posedge tracer_clk);
        #1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_disp_color", disp_color, 0);
        checkOutput("reset_bank_sel", bank_sel, 0);

        // Raster frame with the coordinate-derived colour; vsync mid-fill and on the last pixel.
        for (int i = 0; i < NPIX; i++) begin
            applyStimulus(0, 1, i % 128, i / 128, ((i / 128) % 64) * 64 + (i % 128) % 64,
                          (i == 4000) || (i == NPIX - 1),
                          $urandom_range(127), $urandom_range(63));
            if (i == 4000) begin
                checkOutput("midfill_bank_sel", bank_sel, 0);
                checkOutput("midfill_frame_done", frame_done, 0);
                checkOutput("midfill_ready", pix_ready, 1);
            end
        end
        checkOutput("last_pix_ready", pix_ready, 0);
        for (int k = 0; k < 3; k++)
            applyStimulus(0, 1, k, 0, 12'hFFF, 0, 10, 5);
        applyStimulus(0, 0, 0, 0, 0, 1, 10, 5);
        checkOutput("swap_frame_done", frame_done, 1);
        checkOutput("swap_bank_sel", bank_sel, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 10, 5);
        checkOutput("readback_5_10", disp_color, 12'h14A);
        checkOutput("frame_done_one_cycle", frame_done, 0);

        // Random-valid fill into bank 0 with random colours and random display reads.
        dut_transfers = 0;
        guard = 0;
        while (pix_ready && guard < 40000) begin
            applyStimulus(0, $urandom_range(1), ref_exp % 128, ref_exp / 128,
                          $urandom_range(4095), 0, $urandom_range(127), $urandom_range(63));
            guard++;
        end
        checkOutput("random_fill_transfers", dut_transfers, NPIX);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("swap2_bank_sel", bank_sel, 0);

        // Out-of-order pixel, then reset partway through the frame.
        applyStimulus(0, 1, 0, 0, $urandom_range(4095), 0, 0, 0);
        applyStimulus(0, 1, 1, 0, $urandom_range(4095), 0, 0, 0);
        checkOutput("in_order_seq_err", seq_err, 0);
        applyStimulus(0, 1, 3, 0, $urandom_range(4095), 0, 0, 0);
        checkOutput("skip_seq_err", seq_err, 1);
        for (int i = 4; i < 1000; i++)
            applyStimulus(0, 1, i % 128, i / 128, $urandom_range(4095), 0,
                          $urandom_range(127), $urandom_range(63));
        checkOutput("sticky_seq_err", seq_err, 1);
        applyStimulus(1, 1, 1000 % 128, 1000 / 128, 0, 0, 0, 0);
        checkOutput("rst_seq_err", seq_err, 0);
        checkOutput("rst_bank_sel", bank_sel, 0);
        for (int i = 0; i < NPIX; i++)
            applyStimulus(0, 1, i % 128, i / 128, $urandom_range(4095), 0,
                          $urandom_range(127), $urandom_range(63));
        checkOutput("restart_seq_err", seq_err, 0);
        checkOutput("restart_full_ready", pix_ready, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 64; k++)
            applyStimulus(0, 0, 0, 0, 0, 0, $urandom_range(127), $urandom_range(63));
        checkOutput("final_bank_sel", bank_sel, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
